// File: rtl/axi_buf_pkg.sv
// Shared types and width helpers for the AXI W-channel burst buffer.
package axi_buf_pkg;

   // Release policy for buffered beats
   typedef enum logic {
      BUF_CUT_THROUGH = 1'b0,
      BUF_STORE_FWD   = 1'b1
   } buf_mode_e;

   // Deadlock-guard state for bursts longer than the buffer
   typedef enum logic {
      FB_IDLE     = 1'b0,
      FB_FALLBACK = 1'b1
   } fb_state_e;

   // Counter width able to hold 0..depth inclusive
   function automatic int unsigned cnt_width_f(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Pointer width for a power-of-two depth (at least one bit)
   function automatic int unsigned ptr_width_f(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/axi_buf_fifo_mem.sv
// Register-array FIFO storage: one write port, one fall-through read port.
// Occupancy is tracked by the parent; pointers wrap naturally at DEPTH.
module axi_buf_fifo_mem
   import axi_buf_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o
);

   localparam int unsigned PTR_W = ptr_width_f(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

   // Pointer advance on write and read
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en_i) rd_ptr_d = rd_ptr_q + PTR_W'(1);
   end

   // Pointer registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents need no reset since occupancy gates every read
   always_ff @(posedge clk_i) begin
      if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/axi_w_burst_buffer.sv
// AXI W-channel buffer with cut-through or store-and-forward release of beats.
// Counts complete (last-terminated) bursts held; a fallback state lets a burst
// longer than the buffer drain as cut-through instead of deadlocking.
module axi_w_burst_buffer
   import axi_buf_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH    = 32,
   parameter  int unsigned USER_WIDTH    = 1,
   parameter  int unsigned BUFFER_DEPTH  = 8,
   parameter  int unsigned STORE_AND_FWD = 0,
   localparam int unsigned STRB_WIDTH    = DATA_WIDTH / 8,
   localparam int unsigned CNT_WIDTH     = cnt_width_f(BUFFER_DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  slave_valid_i,
   input  logic [DATA_WIDTH-1:0] slave_data_i,
   input  logic [STRB_WIDTH-1:0] slave_strb_i,
   input  logic [USER_WIDTH-1:0] slave_user_i,
   input  logic                  slave_last_i,
   output logic                  slave_ready_o,
   output logic                  master_valid_o,
   output logic [DATA_WIDTH-1:0] master_data_o,
   output logic [STRB_WIDTH-1:0] master_strb_o,
   output logic [USER_WIDTH-1:0] master_user_o,
   output logic                  master_last_o,
   input  logic                  master_ready_i,
   output logic [CNT_WIDTH-1:0]  fill_o,
   output logic [CNT_WIDTH-1:0]  bursts_o,
   output logic                  long_burst_o
);

   localparam int unsigned           ENTRY_W  = USER_WIDTH + STRB_WIDTH + DATA_WIDTH + 1;
   localparam buf_mode_e             MODE     = (STORE_AND_FWD != 0) ? BUF_STORE_FWD : BUF_CUT_THROUGH;
   localparam logic [CNT_WIDTH-1:0]  FULL_CNT = CNT_WIDTH'(BUFFER_DEPTH);

   logic [CNT_WIDTH-1:0]  fill_q, fill_d;
   logic [CNT_WIDTH-1:0]  bursts_q, bursts_d;
   fb_state_e             state_q, state_d;
   logic                  long_burst_q, long_burst_d;

   logic                  full;
   logic                  push;
   logic                  pop;
   logic                  push_last;
   logic                  pop_last;
   logic                  out_valid;
   logic [ENTRY_W-1:0]    wr_entry;
   logic [ENTRY_W-1:0]    rd_entry;
   logic [USER_WIDTH-1:0] head_user;
   logic [STRB_WIDTH-1:0] head_strb;
   logic [DATA_WIDTH-1:0] head_data;
   logic                  head_last;

   // Handshakes; ready depends on registered occupancy only
   assign full      = (fill_q == FULL_CNT);
   assign push      = slave_valid_i & ~full;
   assign pop       = out_valid & master_ready_i;
   assign push_last = push & slave_last_i;
   assign pop_last  = pop & head_last;

   assign wr_entry = {slave_user_i, slave_strb_i, slave_data_i, slave_last_i};
   assign {head_user, head_strb, head_data, head_last} = rd_entry;

   axi_buf_fifo_mem #(
      .WIDTH (ENTRY_W),
      .DEPTH (BUFFER_DEPTH)
   ) u_mem (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_en_i   (push),
      .wr_data_i (wr_entry),
      .rd_en_i   (pop),
      .rd_data_o (rd_entry)
   );

   // Release gating: store-and-forward waits for a complete burst or fallback
   always_comb begin
      out_valid = (fill_q != '0);
      if (MODE == BUF_STORE_FWD) begin
         out_valid = (fill_q != '0) & ((bursts_q != '0) | (state_q == FB_FALLBACK));
      end
   end

   // Beat and burst occupancy counters, next value
   always_comb begin
      fill_d   = fill_q;
      bursts_d = bursts_q;
      unique case ({push, pop})
         2'b10:   fill_d = fill_q + CNT_WIDTH'(1);
         2'b01:   fill_d = fill_q - CNT_WIDTH'(1);
         default: fill_d = fill_q;
      endcase
      unique case ({push_last, pop_last})
         2'b10:   bursts_d = bursts_q + CNT_WIDTH'(1);
         2'b01:   bursts_d = bursts_q - CNT_WIDTH'(1);
         default: bursts_d = bursts_q;
      endcase
   end

   // Counter registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fill_q   <= '0;
         bursts_q <= '0;
      end else begin
         fill_q   <= fill_d;
         bursts_q <= bursts_d;
      end
   end

   // Fallback FSM state register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= FB_IDLE;
         long_burst_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         long_burst_q <= long_burst_d;
      end
   end

   // Fallback FSM next state: full with no complete burst can never release,
   // so fall back until the oversized burst's last beat leaves
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FB_IDLE: begin
            if ((MODE == BUF_STORE_FWD) && full && (bursts_q == '0)) state_d = FB_FALLBACK;
         end
         FB_FALLBACK: begin
            if (pop_last) state_d = FB_IDLE;
         end
      endcase
   end

   // Fallback FSM output: one-cycle pulse on entry
   always_comb begin
      long_burst_d = 1'b0;
      if ((state_q == FB_IDLE) && (state_d == FB_FALLBACK)) long_burst_d = 1'b1;
   end

   // Output drive; payload reads zero while nothing is offered
   assign slave_ready_o  = ~full;
   assign master_valid_o = out_valid;
   assign master_data_o  = out_valid ? head_data : '0;
   assign master_strb_o  = out_valid ? head_strb : '0;
   assign master_user_o  = out_valid ? head_user : '0;
   assign master_last_o  = out_valid & head_last;
   assign fill_o         = fill_q;
   assign bursts_o       = bursts_q;
   assign long_burst_o   = long_burst_q;

endmodule

// File: tb/tb_axi_w_burst_buffer.sv
// Bench for axi_w_burst_buffer: instance 0 is cut-through, instance 1 store-and-forward.
module tb_axi_w_burst_buffer;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  s;
      logic        u;
      logic        l;
   } beat_t;

   typedef struct {
      bit          v;
      logic [31:0] d;
      bit          l;
      bit          e_ready;
      bit          e_valid;
      logic [31:0] e_data;
      bit          e_last;
      int          e_fill;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        sv [2];
   logic [31:0] sd [2];
   logic [3:0]  ss [2];
   logic        su [2];
   logic        sl [2];
   logic        sr [2];
   logic        mv [2];
   logic [31:0] md [2];
   logic [3:0]  ms [2];
   logic        mu [2];
   logic        ml [2];
   logic        mr [2];
   logic [2:0]  fill [2];
   logic [2:0]  bursts [2];
   logic        lb [2];

   // Reference model: ordered beat list per instance plus fallback flag
   beat_t       mbuf [2][8];
   int          mcnt [2];
   bit          mfb [2];
   bit          mlb [2];

   logic [31:0] rx_d [2][64];
   bit          rx_l [2][64];
   int          rx_n [2];

   int          n_chk;
   int          n_fail;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      axi_w_burst_buffer #(
         .DATA_WIDTH    (32),
         .USER_WIDTH    (1),
         .BUFFER_DEPTH  (DEPTH),
         .STORE_AND_FWD (g)
      ) u_dut (
         .clk_i          (clk),
         .rst_i          (rst),
         .slave_valid_i  (sv[g]),
         .slave_data_i   (sd[g]),
         .slave_strb_i   (ss[g]),
         .slave_user_i   (su[g]),
         .slave_last_i   (sl[g]),
         .slave_ready_o  (sr[g]),
         .master_valid_o (mv[g]),
         .master_data_o  (md[g]),
         .master_strb_o  (ms[g]),
         .master_user_o  (mu[g]),
         .master_last_o  (ml[g]),
         .master_ready_i (mr[g]),
         .fill_o         (fill[g]),
         .bursts_o       (bursts[g]),
         .long_burst_o   (lb[g])
      );
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int m_bursts(input int i);
      int b = 0;
      for (int k = 0; k < mcnt[i]; k++) if (mbuf[i][k].l) b++;
      return b;
   endfunction

   function automatic bit m_valid(input int i);
      return (mcnt[i] > 0) && ((i == 0) || (m_bursts(i) > 0) || mfb[i]);
   endfunction

   // Compare both instances against the model, then advance one clock
   task automatic cycle();
      bit    push [2];
      bit    pop [2];
      bit    enter [2];
      string p;
      for (int i = 0; i < 2; i++) begin
         p = $sformatf("d%0d_", i);
         chk({p, "ready"},  64'(sr[i]),     64'(mcnt[i] < DEPTH));
         chk({p, "valid"},  64'(mv[i]),     64'(m_valid(i)));
         chk({p, "fill"},   64'(fill[i]),   64'(mcnt[i]));
         chk({p, "bursts"}, 64'(bursts[i]), 64'(m_bursts(i)));
         chk({p, "long"},   64'(lb[i]),     64'(mlb[i]));
         if (m_valid(i)) begin
            chk({p, "data"}, 64'(md[i]), 64'(mbuf[i][0].d));
            chk({p, "strb"}, 64'(ms[i]), 64'(mbuf[i][0].s));
            chk({p, "user"}, 64'(mu[i]), 64'(mbuf[i][0].u));
            chk({p, "last"}, 64'(ml[i]), 64'(mbuf[i][0].l));
         end
         push[i]  = sv[i] && (mcnt[i] < DEPTH);
         pop[i]   = m_valid(i) && mr[i];
         enter[i] = (i == 1) && !mfb[i] && (mcnt[i] == DEPTH) && (m_bursts(i) == 0);
         if (mv[i] === 1'b1 && mr[i] === 1'b1 && rx_n[i] < 64) begin
            rx_d[i][rx_n[i]] = md[i];
            rx_l[i][rx_n[i]] = ml[i];
            rx_n[i]++;
         end
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            mcnt[i] = 0;
            mfb[i]  = 1'b0;
            mlb[i]  = 1'b0;
         end else begin
            mlb[i] = enter[i];
            if (pop[i]) begin
               if (mbuf[i][0].l) mfb[i] = 1'b0;
               for (int k = 0; k < mcnt[i] - 1; k++) mbuf[i][k] = mbuf[i][k + 1];
               mcnt[i]--;
            end
            if (enter[i]) mfb[i] = 1'b1;
            if (push[i]) begin
               mbuf[i][mcnt[i]] = {sd[i], ss[i], su[i], sl[i]};
               mcnt[i]++;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic drive(input int i, input bit v, input logic [31:0] d, input bit l, input bit r);
      sv[i] = v;
      sd[i] = d;
      ss[i] = d[3:0] ^ 4'h5;
      su[i] = d[0];
      sl[i] = l;
      mr[i] = r;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 1);
      drive(1, 0, 0, 0, 1);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      rx_n[0] = 0;
      rx_n[1] = 0;
   endtask

   task automatic drain(input int i, input int budget);
      int c = 0;
      drive(i, 0, 0, 0, 1);
      while (fill[i] != 0 && c < budget) begin
         cycle();
         c++;
      end
      chk($sformatf("d%0d_drain_done", i), 64'(fill[i]), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tab [6];
      int   kp;
      int   lbn;
      int   maxf;
      bit   acc;
      bit   exp_sr [5];

      tab[0] = '{0, 32'h0,  0, 1, 0, 32'h0,  0, 0};
      tab[1] = '{1, 32'hA0, 0, 1, 0, 32'h0,  0, 0};
      tab[2] = '{1, 32'hA1, 0, 1, 1, 32'hA0, 0, 1};
      tab[3] = '{1, 32'hA2, 1, 1, 1, 32'hA1, 0, 1};
      tab[4] = '{0, 32'h0,  0, 1, 1, 32'hA2, 1, 1};
      tab[5] = '{0, 32'h0,  0, 1, 0, 32'h0,  0, 0};
      exp_sr = '{1, 1, 1, 0, 0};

      n_chk  = 0;
      n_fail = 0;
      for (int i = 0; i < 2; i++) begin
         drive(i, 0, 0, 0, 1);
         mcnt[i] = 0;
         mfb[i]  = 1'b0;
         mlb[i]  = 1'b0;
         rx_n[i] = 0;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Cut-through 3-beat burst, back-to-back, vector table
      for (int r = 0; r < 6; r++) begin
         drive(0, tab[r].v, tab[r].d, tab[r].l, 1);
         chk($sformatf("t1_ready_r%0d", r), 64'(sr[0]),   64'(tab[r].e_ready));
         chk($sformatf("t1_valid_r%0d", r), 64'(mv[0]),   64'(tab[r].e_valid));
         chk($sformatf("t1_fill_r%0d", r),  64'(fill[0]), 64'(tab[r].e_fill));
         chk($sformatf("t1_last_r%0d", r),  64'(ml[0]),   64'(tab[r].e_last));
         if (tab[r].e_valid) chk($sformatf("t1_data_r%0d", r), 64'(md[0]), 64'(tab[r].e_data));
         cycle();
      end

      // Store-and-forward: 2-beat burst with a 3-cycle upstream gap
      do_reset();
      drive(1, 1, 32'hB0, 0, 1);
      cycle();
      for (int g = 0; g < 3; g++) begin
         drive(1, 0, 0, 0, 1);
         chk($sformatf("t2_gap_valid_%0d", g), 64'(mv[1]), 64'd0);
         cycle();
      end
      drive(1, 1, 32'hB1, 1, 1);
      chk("t2_pre_last_valid", 64'(mv[1]), 64'd0);
      cycle();
      drive(1, 0, 0, 0, 1);
      chk("t2_beat0_valid", 64'(mv[1]), 64'd1);
      chk("t2_beat0_data",  64'(md[1]), 64'hB0);
      cycle();
      chk("t2_beat1_valid", 64'(mv[1]), 64'd1);
      chk("t2_beat1_data",  64'(md[1]), 64'hB1);
      chk("t2_beat1_last",  64'(ml[1]), 64'd1);
      cycle();
      chk("t2_empty_valid", 64'(mv[1]), 64'd0);

      // Store-and-forward: 6-beat burst forces fallback
      do_reset();
      kp = 0; lbn = 0; maxf = 0;
      for (int c = 0; c < 40 && !(kp == 6 && fill[1] == 0); c++) begin
         drive(1, kp < 6, 32'hC0 + kp, kp == 5, 1);
         if (lb[1]) lbn++;
         if (int'(fill[1]) > maxf) maxf = int'(fill[1]);
         if (fill[1] == 3'd4) chk("t3_full_bursts", 64'(bursts[1]), 64'd0);
         acc = sv[1] && sr[1];
         cycle();
         if (acc) kp++;
      end
      chk("t3_done", 64'(kp == 6 && fill[1] == 0), 64'd1);
      chk("t3_long_pulses", 64'(lbn), 64'd1);
      chk("t3_max_fill", 64'(maxf), 64'd4);
      chk("t3_rx_count", 64'(rx_n[1]), 64'd6);
      for (int j = 0; j < 6; j++) chk($sformatf("t3_rx_%0d", j), 64'(rx_d[1][j]), 64'(32'hC0 + j));
      chk("t3_rx_last", 64'(rx_l[1][5]), 64'd1);
      drive(1, 1, 32'hC8, 0, 1);
      cycle();
      drive(1, 0, 0, 0, 1);
      cycle();
      chk("t3_fallback_cleared", 64'(mv[1]), 64'd0);
      drive(1, 1, 32'hC9, 1, 1);
      cycle();
      drain(1, 10);

      // Full FIFO with push and pop offered together
      do_reset();
      for (int k = 0; k < 4; k++) begin
         drive(0, 1, 32'hD0 + k, 1, 0);
         cycle();
      end
      drive(0, 1, 32'hD4, 1, 1);
      chk("t4_full_ready",  64'(sr[0]),     64'd0);
      chk("t4_full_fill",   64'(fill[0]),   64'd4);
      chk("t4_full_bursts", 64'(bursts[0]), 64'd4);
      chk("t4_full_data",   64'(md[0]),     64'hD0);
      cycle();
      chk("t4_next_ready",  64'(sr[0]),     64'd1);
      chk("t4_next_fill",   64'(fill[0]),   64'd3);
      chk("t4_next_bursts", 64'(bursts[0]), 64'd3);
      chk("t4_next_data",   64'(md[0]),     64'hD1);
      cycle();
      drive(0, 0, 0, 0, 1);
      chk("t4_both_fill",   64'(fill[0]),   64'd3);
      chk("t4_both_bursts", 64'(bursts[0]), 64'd3);
      chk("t4_both_data",   64'(md[0]),     64'hD2);
      drain(0, 10);
      chk("t4_rx_count", 64'(rx_n[0]), 64'd5);
      chk("t4_rx_4",     64'(rx_d[0][4]), 64'hD4);

      // Downstream stall of 5 cycles mid-burst
      do_reset();
      drive(0, 1, 32'hE0, 0, 1);
      cycle();
      drive(0, 1, 32'hE1, 0, 1);
      cycle();
      kp = 2;
      for (int k = 0; k < 5; k++) begin
         drive(0, 1, 32'hE0 + kp, kp == 5, 0);
         chk($sformatf("t5_hold_valid_%0d", k), 64'(mv[0]), 64'd1);
         chk($sformatf("t5_hold_data_%0d", k),  64'(md[0]), 64'hE1);
         chk($sformatf("t5_hold_last_%0d", k),  64'(ml[0]), 64'd0);
         chk($sformatf("t5_ready_%0d", k),      64'(sr[0]), 64'(exp_sr[k]));
         acc = sr[0];
         cycle();
         if (acc) kp++;
      end
      for (int c = 0; c < 20 && !(kp == 6 && fill[0] == 0); c++) begin
         drive(0, kp < 6, 32'hE0 + kp, kp == 5, 1);
         acc = sv[0] && sr[0];
         cycle();
         if (acc) kp++;
      end
      chk("t5_rx_count", 64'(rx_n[0]), 64'd6);
      for (int j = 0; j < 6; j++) chk($sformatf("t5_rx_%0d", j), 64'(rx_d[0][j]), 64'(32'hE0 + j));
      chk("t5_rx_last", 64'(rx_l[0][5]), 64'd1);

      // Reset mid-burst with three beats stored
      do_reset();
      for (int k = 0; k < 3; k++) begin
         drive(0, 1, 32'hF0 + k, 0, 0);
         cycle();
      end
      chk("t6_pre_fill", 64'(fill[0]), 64'd3);
      do_reset();
      chk("t6_fill",   64'(fill[0]),   64'd0);
      chk("t6_bursts", 64'(bursts[0]), 64'd0);
      chk("t6_valid",  64'(mv[0]),     64'd0);
      chk("t6_data",   64'(md[0]),     64'd0);
      chk("t6_last",   64'(ml[0]),     64'd0);
      chk("t6_long",   64'(lb[0]),     64'd0);
      drive(0, 1, 32'h60, 0, 1);
      cycle();
      drive(0, 1, 32'h61, 1, 1);
      cycle();
      drain(0, 10);
      chk("t6_rx_count", 64'(rx_n[0]), 64'd2);
      chk("t6_rx_0",     64'(rx_d[0][0]), 64'h60);
      chk("t6_rx_1",     64'(rx_d[0][1]), 64'h61);
      chk("t6_rx_last",  64'(rx_l[0][1]), 64'd1);

      // Randomized traffic on both instances against the model
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         int th;
         th = (((c / 250) % 3) == 0) ? 2 : ((((c / 250) % 3) == 1) ? 6 : 10);
         for (int i = 0; i < 2; i++) begin
            sv[i] = ($urandom_range(0, 3) != 0);
            sd[i] = $urandom;
            ss[i] = 4'($urandom);
            su[i] = 1'($urandom);
            sl[i] = ($urandom_range(0, (i == 1) ? 5 : 3) == 0);
            mr[i] = ($urandom_range(0, 9) < th);
         end
         rst = ($urandom_range(0, 299) == 0);
         cycle();
      end
      rst = 1'b0;
      drive(0, 0, 0, 0, 1);
      drive(1, 0, 0, 0, 1);
      repeat (10) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
